// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter in front of a single-port 64-bit memory.
// The fetch port reads 32-bit words (two per memory word, selected by i_addr[0]).
// The data port does 64-bit loads and stores. Only one transaction is in flight.
// Grants, m_en and the memory command are combinational in the IDLE cycle.
// Read data is returned through registered rvalid/rdata outputs.
// Note: rst_n is active-high (1 = reset asserted); the name is kept for drop-in use.
module mem_arbiter #(
  parameter int unsigned addr_bits  = 6,
  parameter int unsigned mem_lat    = 2,
  parameter int unsigned starve_max = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_req,
  input  logic [addr_bits-1:0] i_addr,
  output logic                 i_gnt,
  output logic                 i_rvalid,
  output logic [31:0]          i_rdata,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [addr_bits-1:0] d_addr,
  input  logic [63:0]          d_wdata,
  output logic                 d_gnt,
  output logic                 d_rvalid,
  output logic [63:0]          d_rdata,
  output logic                 m_en,
  output logic                 m_we,
  output logic [addr_bits-1:0] m_addr,
  output logic [63:0]          m_wdata,
  input  logic [63:0]          m_rdata
);

  localparam int unsigned SW = (starve_max < 1) ? 1 : $clog2(starve_max + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(starve_max);
  localparam logic [2:0]    LAT_END    = 3'(mem_lat);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [2:0]    lat_cnt;
  logic [SW-1:0] starve_cnt;
  logic          pend_read;
  logic          pend_fetch;
  logic          pend_half;
  logic          grant_i;
  logic          grant_d;

  // Arbitration: data has priority unless fetch has lost starve_max times in a row.
  // Grants are suppressed while reset is asserted so every output reads 0.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (!rst_n && state == IDLE) begin
      if (i_req && d_req) begin
        if (starve_cnt == STARVE_LIM) grant_i = 1'b1;
        else                          grant_d = 1'b1;
      end else if (i_req) begin
        grant_i = 1'b1;
      end else if (d_req) begin
        grant_d = 1'b1;
      end
    end
  end

  // Memory command steered from the granted requester; idle command is all zero.
  always_comb begin
    i_gnt   = grant_i;
    d_gnt   = grant_d;
    m_en    = grant_i | grant_d;
    m_we    = grant_d & d_we;
    m_addr  = '0;
    m_wdata = '0;
    if (grant_i) begin
      m_addr = {1'b0, i_addr[addr_bits-1:1]};
    end else if (grant_d) begin
      m_addr = d_addr;
      if (d_we) m_wdata = d_wdata;
    end
  end

  // Transaction FSM: latch ownership at grant, count latency, capture read data.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      pend_read  <= 1'b0;
      pend_fetch <= 1'b0;
      pend_half  <= 1'b0;
      i_rvalid   <= 1'b0;
      d_rvalid   <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_i || grant_d) begin
            state      <= BUSY;
            lat_cnt    <= 3'd1;
            pend_fetch <= grant_i;
            pend_read  <= grant_i | ~d_we;
            pend_half  <= grant_i & i_addr[0];
            if (grant_i) begin
              starve_cnt <= '0;
            end else if (i_req && starve_cnt != STARVE_LIM) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
          end
        end
        BUSY: begin
          if (lat_cnt == LAT_END) begin
            state   <= IDLE;
            lat_cnt <= '0;
            if (pend_read) begin
              if (pend_fetch) begin
                i_rvalid <= 1'b1;
                i_rdata  <= pend_half ? m_rdata[63:32] : m_rdata[31:0];
              end else begin
                d_rvalid <= 1'b1;
                d_rdata  <= m_rdata;
              end
            end
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with mem_lat=2, starve_max=3.
// A behavioural memory answers DUT commands; expected read data comes from the
// bench's own reference memory and is queued when each request is driven.
module tb_mem_arbiter;

  localparam int unsigned AW = 6;

  logic          clk;
  logic          rst_n;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [31:0]   i_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [63:0]   d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [63:0]   d_rdata;
  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [63:0]   m_wdata;
  logic [63:0]   m_rdata;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [31:0] exp_i_q [$];
  logic [63:0] exp_d_q [$];
  logic [63:0] ref_mem [64];

  mem_arbiter #(.addr_bits(AW), .mem_lat(2), .starve_max(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Initial memory image shared by the memory model and the reference copy.
  function automatic logic [63:0] seed(input int unsigned a);
    if (a == 2) return 64'hAAAA_BBBB_CCCC_DDDD;
    return {8'hC3, 8'(a), 16'h5A00 + 16'(a), 8'h3C, 8'(a * 5), 16'hE100 ^ 16'(a * 7)};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory model: read data valid two cycles after the m_en cycle, junk otherwise.
  logic          p1_v = 1'b0;
  logic          p2_v = 1'b0;
  logic [AW-1:0] p1_a = '0;
  logic [AW-1:0] p2_a = '0;
  bit            wr_flag [64];
  logic [63:0]   wr_data [64];

  always @(posedge clk) begin
    p1_v <= m_en && !m_we;
    p1_a <= m_addr;
    p2_v <= p1_v;
    p2_a <= p1_a;
    if (m_en && m_we) begin
      wr_flag[m_addr] <= 1'b1;
      wr_data[m_addr] <= m_wdata;
    end
  end

  always_comb begin
    m_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    if (p2_v) m_rdata = wr_flag[p2_a] ? wr_data[p2_a] : seed(32'(p2_a));
  end

  // Scoreboard side: every rvalid must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!(m_en && m_we)) check("m_wdata_zero", m_wdata, 64'd0);
    if (i_rvalid) begin
      check("i_exp_pending", 64'(exp_i_q.size() != 0), 64'd1);
      if (exp_i_q.size() != 0) check("i_rdata", 64'(i_rdata), 64'(exp_i_q.pop_front()));
    end
    if (d_rvalid) begin
      check("d_exp_pending", 64'(exp_d_q.size() != 0), 64'd1);
      if (exp_d_q.size() != 0) check("d_rdata", d_rdata, exp_d_q.pop_front());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b1; i_req = 1'b1; i_addr = 6'd3;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = seed(i);

    // Reset state, with a fetch request pending that must not be granted.
    settle();
    check("rst_i_gnt",  64'(i_gnt), 64'd0);
    check("rst_m_en",   64'(m_en), 64'd0);
    check("rst_m_addr", 64'(m_addr), 64'd0);
    check("rst_rvalid", 64'({i_rvalid, d_rvalid}), 64'd0);
    check("rst_i_rdata", 64'(i_rdata), 64'd0);
    check("rst_d_rdata", d_rdata, 64'd0);
    step(); step();

    // Grant in the first cycle after release; odd address selects upper half.
    rst_n = 1'b0;
    exp_i_q.push_back(ref_mem[1][63:32]);
    settle();
    check("post_rst_i_gnt", 64'(i_gnt), 64'd1);
    check("post_rst_m_addr", 64'(m_addr), 64'd1);
    step(); i_req = 1'b0;
    settle(); check("busy_no_gnt", 64'({i_gnt, d_gnt, m_en}), 64'd0);
    step(); step();
    settle(); check("fetch_rvalid", 64'(i_rvalid), 64'd1);
    step();

    // Fetch-only example.
    i_req = 1'b1; i_addr = 6'd5;
    exp_i_q.push_back(32'hAAAA_BBBB);
    settle();
    check("f_i_gnt", 64'({i_gnt, d_gnt}), 64'd2);
    check("f_m_en_we", 64'({m_en, m_we}), 64'd2);
    check("f_m_addr", 64'(m_addr), 64'd2);
    step(); i_req = 1'b0;
    settle(); check("f_busy1", 64'({i_gnt, m_en, i_rvalid}), 64'd0);
    step();
    settle(); check("f_busy2", 64'({i_gnt, m_en, i_rvalid}), 64'd0);
    step();
    settle(); check("f_rvalid", 64'(i_rvalid), 64'd1);
    step();

    // Simultaneous requests: data first, fetch right after.
    i_req = 1'b1; i_addr = 6'd6;
    d_req = 1'b1; d_we = 1'b0; d_addr = 6'd10;
    exp_d_q.push_back(ref_mem[10]);
    exp_i_q.push_back(ref_mem[3][31:0]);
    settle();
    check("sim_gnt", 64'({d_gnt, i_gnt}), 64'd2);
    check("sim_m_addr", 64'(m_addr), 64'd10);
    step(); d_req = 1'b0;
    settle(); check("sim_busy1", 64'({d_gnt, i_gnt}), 64'd0);
    step();
    settle(); check("sim_busy2", 64'({d_gnt, i_gnt}), 64'd0);
    step();
    settle();
    check("sim_d_rvalid", 64'(d_rvalid), 64'd1);
    check("sim_i_gnt", 64'(i_gnt), 64'd1);
    check("sim_i_m_addr", 64'(m_addr), 64'd3);
    step(); i_req = 1'b0;
    step(); step();
    settle(); check("sim_i_rvalid", 64'(i_rvalid), 64'd1);
    step();

    // Starvation: both held high -> D,D,D,I,D,D,D,I.
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; i_addr = 6'd1; d_addr = 6'd30;
    for (int k = 0; k < 8; k++) begin
      if (k % 4 == 3) exp_i_q.push_back(i_addr[0] ? ref_mem[i_addr >> 1][63:32] : ref_mem[i_addr >> 1][31:0]);
      else            exp_d_q.push_back(ref_mem[d_addr]);
      settle();
      check("starve_gnt", 64'({d_gnt, i_gnt}), (k % 4 == 3) ? 64'd1 : 64'd2);
      step();
      if (k % 4 == 3) i_addr = i_addr + 6'd3;
      else            d_addr = d_addr + 6'd1;
      step(); step();
    end
    i_req = 1'b0; d_req = 1'b0;

    // Data write, then read back through the same address.
    d_req = 1'b1; d_we = 1'b1; d_addr = 6'd9; d_wdata = 64'h1234;
    ref_mem[9] = 64'h1234;
    settle();
    check("wr_gnt", 64'(d_gnt), 64'd1);
    check("wr_m_en_we", 64'({m_en, m_we}), 64'd3);
    check("wr_m_addr", 64'(m_addr), 64'd9);
    check("wr_m_wdata", m_wdata, 64'h1234);
    step(); d_req = 1'b0; d_we = 1'b0; d_wdata = '0;
    settle(); check("wr_no_rvalid1", 64'(d_rvalid), 64'd0);
    step();
    settle(); check("wr_no_rvalid2", 64'({d_rvalid, m_en}), 64'd0);
    step();
    d_req = 1'b1; d_we = 1'b0; d_addr = 6'd9; d_wdata = 64'hFFFF_0000_FFFF;
    exp_d_q.push_back(ref_mem[9]);
    settle();
    check("wr_next_gnt", 64'({d_gnt, d_rvalid}), 64'd2);
    check("rd_m_wdata", m_wdata, 64'd0);
    step(); d_req = 1'b0;
    step(); step();

    // Back-to-back loads: new grant concurrent with previous rvalid.
    d_req = 1'b1; d_addr = 6'd12;
    exp_d_q.push_back(ref_mem[12]);
    settle(); check("b2b_rvalid_gnt", 64'({d_rvalid, d_gnt}), 64'd3);
    step(); d_req = 1'b0;
    step(); step();
    settle(); check("b2b_rvalid2", 64'(d_rvalid), 64'd1);
    step();

    // Reset in the cycle after a read grant; the read is discarded.
    i_req = 1'b1; i_addr = 6'd7;
    settle(); check("rr_gnt", 64'(i_gnt), 64'd1);
    step(); i_req = 1'b1; i_addr = 6'd13;
    #2 rst_n = 1'b1;
    #1;
    check("rr_async_ctl", 64'({i_gnt, d_gnt, m_en, m_we, i_rvalid, d_rvalid}), 64'd0);
    check("rr_async_addr", 64'(m_addr), 64'd0);
    check("rr_async_i_rdata", 64'(i_rdata), 64'd0);
    check("rr_async_d_rdata", d_rdata, 64'd0);
    step(); step();
    rst_n = 1'b0;
    exp_i_q.push_back(ref_mem[6][63:32]);
    settle();
    check("rr_post_gnt", 64'(i_gnt), 64'd1);
    check("rr_post_m_addr", 64'(m_addr), 64'd6);
    step(); i_req = 1'b0;
    settle(); check("rr_no_rvalid1", 64'(i_rvalid), 64'd0);
    step();
    settle(); check("rr_no_rvalid2", 64'(i_rvalid), 64'd0);
    step();
    settle(); check("rr_rvalid", 64'(i_rvalid), 64'd1);

    repeat (4) step();
    check("i_queue_drained", 64'(exp_i_q.size()), 64'd0);
    check("d_queue_drained", 64'(exp_d_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter addr_bits, default 6, memory word-address width for both requesters.
REQ-002 SHALL have parameter mem_lat, default 2, memory read latency in cycles, legal range 1..4.
REQ-003 SHALL have parameter starve_max, default 3, maximum consecutive fetch losses before a forced fetch grant.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-high (1 = reset asserted).
REQ-006 SHALL have ports i_req/i_addr  input  1/addr_bits  fetch request, 32-bit-word address.
REQ-007 SHALL have ports i_gnt/i_rvalid  output  1/1  fetch grant pulse, fetch data valid pulse.
REQ-008 SHALL have port i_rdata  output  32  fetched instruction.
REQ-009 SHALL have ports d_req/d_we/d_addr/d_wdata  input  1/1/addr_bits/64  data request, write enable, 64-bit-word address, write data.
REQ-010 SHALL have ports d_gnt/d_rvalid/d_rdata  output  1/1/64  data grant pulse, load valid pulse, load data.
REQ-011 SHALL have ports m_en/m_we/m_addr/m_wdata  output  1/1/addr_bits/64  single-port memory command.
REQ-012 SHALL have port m_rdata  input  64  memory read data, valid mem_lat cycles after the m_en cycle.

Function
REQ-013 SHALL implement states IDLE and BUSY plus a latency counter; exactly one transaction outstanding at a time.
REQ-014 In IDLE with at least one req high, SHALL grant one requester that cycle: gnt=1, m_en=1, command driven combinationally from the granted inputs, next state BUSY.
REQ-015 Arbitration: data wins when both request, unless starve_cnt==starve_max, in which case fetch wins.
REQ-016 starve_cnt SHALL increment (saturating at starve_max) on each grant to data while i_req=1, and clear on every fetch grant.
REQ-017 Fetch command: m_we=0, m_addr={1'b0, i_addr[addr_bits-1:1]}; the arbiter SHALL latch i_addr[0] as the half selector.
REQ-018 Data command: m_we=d_we, m_addr=d_addr, m_wdata=d_wdata.
REQ-019 BUSY SHALL last exactly mem_lat cycles; i_gnt, d_gnt, m_en SHALL be 0 throughout BUSY.
REQ-020 For a read granted in cycle T, SHALL capture m_rdata in cycle T+mem_lat and assert the owner's rvalid for one cycle in T+mem_lat+1.
REQ-021 i_rdata SHALL equal captured [31:0] when the half selector is 0, [63:32] when it is 1; d_rdata SHALL equal the full captured word.
REQ-022 rdata outputs SHALL hold their value until the next capture.
REQ-023 Writes SHALL occupy BUSY for mem_lat cycles and SHALL NOT assert d_rvalid.
REQ-024 The state returns to IDLE in cycle T+mem_lat+1; a new grant SHALL be possible in that same cycle, concurrent with rvalid.
REQ-025 Requesters hold req and payload stable until gnt; req low in the gnt cycle+1 means no new request.
REQ-026 m_wdata SHALL be 0 whenever m_en=0 or m_we=0.

Reset
REQ-027 While rst_n=1, and asynchronously on assertion: state=IDLE, counter=0, starve_cnt=0, all gnt/rvalid/m_en/m_we=0, m_addr=0, rdata outputs=0.
REQ-028 Reset asserted mid-BUSY SHALL discard the pending capture; no rvalid SHALL follow reset release.
REQ-029 The first grant SHALL be possible in the first rising edge cycle after rst_n deasserts.

Verification (mem_lat=2, starve_max=3)
REQ-030 Fetch-only: i_req=1, i_addr=5 at T, m_rdata=64'hAAAA_BBBB_CCCC_DDDD at T+2 -> i_gnt@T, m_addr=2, i_rvalid@T+3, i_rdata=32'hAAAA_BBBB.
REQ-031 Simultaneous: i_req=d_req=1 at T -> d_gnt@T; i_gnt@T+3; no gnt in T+1..T+2.
REQ-032 Starvation: d_req and i_req held high continuously -> grant order D,D,D,I,D,D,D,I; starve_cnt 0 after each I.
REQ-033 Data write: d_we=1, d_addr=9, d_wdata=64'h1234 -> m_en=1, m_we=1, m_addr=9, m_wdata=64'h1234 @T; d_rvalid never asserted; next grant possible @T+3.
REQ-034 Reset at T+1 of a read -> all outputs 0 immediately; no rvalid after release; a fetch request after release is granted on the first post-reset edge.
REQ-035 Back-to-back loads (d_req reasserted at T+3) -> d_rvalid and d_gnt both 1 in T+3; second d_rvalid in T+6.
